// File: rtl/sar_pkg.sv
// Shared constants and types for the SAR result buffer.
`timescale 1ns/1ps
package sar_pkg;

  localparam int unsigned SarDataW = 8;

  typedef enum logic {
    Idle,
    Hold
  } avg_phase_e;

endpackage

// File: rtl/sar_fifo.sv
// Show-ahead FIFO with occupancy count; pointers wrap modulo DEPTH.
`timescale 1ns/1ps
module sar_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q;
  logic              wr_en, rd_en;

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign wr_en = push & (~full | rd_en);
  assign rd_en = pop & rd_valid;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LevelW'(1);
        2'b01:   level_q <= level_q - LevelW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_valid = (level_q != '0);
  assign full     = (level_q == LevelW'(DEPTH));
  assign level    = level_q;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/sar_result_buffer.sv
// SAR conversion result buffer: capture on eoc, sticky overflow, FIFO to consumer.
// Define SAR_BUF_AVG_EN to average result pairs before they are queued.
`timescale 1ns/1ps
module sar_result_buffer
  import sar_pkg::*;
#(
  parameter int unsigned DATA_W = SarDataW,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   eoc,
  input  logic [DATA_W-1:0]      sar,
  input  logic                   rd_ready,
  input  logic                   clr_ovf,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   ovf
);

  logic              push, pop, drop;
  logic [DATA_W-1:0] push_data;
  logic              ovf_q, ovf_d;

  assign pop = rd_valid & rd_ready;

`ifdef SAR_BUF_AVG_EN
  avg_phase_e        phase_q, phase_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W:0]   sum;

  always_comb begin
    phase_d   = phase_q;
    a_d       = a_q;
    push      = 1'b0;
    sum       = {1'b0, a_q} + {1'b0, sar} + (DATA_W+1)'(1);
    push_data = DATA_W'(sum >> 1);
    if (eoc) begin
      unique case (phase_q)
        Idle: begin
          a_d     = sar;
          phase_d = Hold;
        end
        Hold: begin
          // Phase returns to Idle whether or not the average is accepted.
          push    = 1'b1;
          phase_d = Idle;
        end
        default: phase_d = Idle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= Idle;
      a_q     <= '0;
    end else begin
      phase_q <= phase_d;
      a_q     <= a_d;
    end
  end
`else
  assign push      = eoc;
  assign push_data = sar;
`endif

  assign drop = push & full & ~pop;

  // Set wins over clear when both happen on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

  sar_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .wdata    (push_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .level    (level),
    .full     (full)
  );

endmodule

// File: tb/tb_sar_result_buffer.sv
// Scoreboard bench for sar_result_buffer; expected entries are queued at stimulus time.
`timescale 1ns/1ps
module tb_sar_result_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       eoc, rd_ready, clr_ovf;
  logic [7:0] sar;
  logic       rd_valid, full, ovf;
  logic [7:0] rd_data;
  logic [2:0] level;

  int         tests = 0;
  int         fails = 0;
  int         model_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  sar_result_buffer #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .eoc      (eoc),
    .sar      (sar),
    .rd_ready (rd_ready),
    .clr_ovf  (clr_ovf),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .level    (level),
    .full     (full),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted read must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got %h, required no entry", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          fails++;
          $display("FAIL pop_data: got %h, required %h", rd_data, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
    end
  endtask

  // Drive one clock of stimulus; returns 1ns after the capturing edge.
  task automatic cycle(input logic e, input logic [7:0] d, input logic rdy, input logic clr);
    bit p;
    bit a;
    eoc = e; sar = d; rd_ready = rdy; clr_ovf = clr;
    p = rdy && (model_cnt > 0);
    a = 1'b0;
`ifndef SAR_BUF_AVG_EN
    a = e && ((model_cnt < 4) || p);
    if (a) exp_q.push_back(d);
`endif
    model_cnt = model_cnt + (a ? 1 : 0) - (p ? 1 : 0);
    @(posedge clk);
    #1;
    eoc = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0; sar = '0;
  endtask

  task automatic exp_push(input logic [7:0] v);
    exp_q.push_back(v);
    model_cnt++;
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_level", level, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_full", full, 0);
    check("rst_rd_data", rd_data, 0);
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; eoc = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0; sar = '0;
    @(posedge clk);
    #1;
    check("reset_level", level, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_full", full, 0);
    check("reset_ovf", ovf, 0);
    check("reset_rd_data", rd_data, 0);
    rst_n = 1'b1;

`ifndef SAR_BUF_AVG_EN
    // Single push visible one cycle later, first edge after reset release.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check("first_rd_valid", rd_valid, 1);
    check("first_rd_data", rd_data, 8'hA5);
    check("first_level", level, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("empty_level", level, 0);
    check("empty_rd_data", rd_data, 0);

    // Fill, then overflow with a fifth result.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full", full, 1);
    check("fill_level", level, 4);
    check("fill_ovf", ovf, 0);
    cycle(1'b1, 8'h05, 1'b0, 1'b0);
    check("drop_ovf", ovf, 1);
    check("drop_level", level, 4);
    check("drop_head_stable", rd_data, 8'h01);

    // Clear colliding with another drop, then clear alone.
    cycle(1'b1, 8'h06, 1'b0, 1'b1);
    check("clr_vs_set_ovf", ovf, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", ovf, 0);

    // Push and pop on the same edge while full.
    cycle(1'b1, 8'h07, 1'b1, 1'b0);
    check("full_pushpop_level", level, 4);
    check("full_pushpop_ovf", ovf, 0);
    check("full_pushpop_full", full, 1);
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_level", level, 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("ready_empty_level", level, 0);
    check("ready_empty_valid", rd_valid, 0);

    // Streaming push/pop across the pointer wrap.
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
    check("stream_level", level, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    check("pre_rst_level", level, 3);
    mid_reset();
    cycle(1'b1, 8'h60, 1'b0, 1'b0);
    check("post_rst_level", level, 1);
    check("post_rst_data", rd_data, 8'h60);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
`else
    // Pairs are averaged with rounding.
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    check("avg_hold_level", level, 0);
    cycle(1'b1, 8'h13, 1'b0, 1'b0);
    exp_push(8'h12);
    check("avg_level1", level, 1);
    check("avg_data1", rd_data, 8'h12);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    exp_push(8'hFF);
    check("avg_level2", level, 2);
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("avg_drain_level", level, 0);

    // Reset with level 3 and a half-collected pair.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h02, 1'b0, 1'b0);
      cycle(1'b1, 8'h04, 1'b0, 1'b0);
      exp_push(8'h03);
    end
    cycle(1'b1, 8'h80, 1'b0, 1'b0);
    check("avg_pre_rst_level", level, 3);
    mid_reset();
    cycle(1'b1, 8'h20, 1'b0, 1'b0);
    check("avg_post_rst_idle", level, 0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    exp_push(8'h21);
    check("avg_post_rst_level", level, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
